action_sequencer: RTL and testbench



---
 rtl/action_sequencer.sv | 116 +++++++++++
 tb/tb_action_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/action_sequencer.sv
// rtl/action_sequencer.sv - walks an action's frame-descriptor list in the action ROM
// and holds each sprite index for its programmed number of frame ticks.
module action_sequencer #(
    parameter int ACT_W = 3,
    parameter int ADDR_W = 8,
    parameter int SPR_W = 8,
    parameter int DUR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     act_req,
    input  logic [ACT_W-1:0]         act_id,
    input  logic                     frame_tick,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DUR_W+SPR_W:0]     rom_data,
    output logic [SPR_W-1:0]         sprite_id,
    output logic                     sprite_valid,
    output logic                     act_busy,
    output logic                     act_done
);
    localparam int SLOT_W = ADDR_W - ACT_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [SPR_W-1:0]   sprite_id_q, sprite_id_d;
    logic               sprite_valid_q, sprite_valid_d;
    logic               act_busy_q, act_busy_d;
    logic               act_done_q, act_done_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;

    logic               desc_last;
    logic [DUR_W-1:0]   desc_dur;
    logic [SPR_W-1:0]   desc_sprite;

    assign desc_last   = rom_data[DUR_W+SPR_W];
    assign desc_dur    = rom_data[DUR_W+SPR_W-1:SPR_W];
    assign desc_sprite = rom_data[SPR_W-1:0];

    always_comb begin
        state_d        = state_q;
        rom_addr_d     = rom_addr_q;
        sprite_id_d    = sprite_id_q;
        sprite_valid_d = sprite_valid_q;
        act_busy_d     = act_busy_q;
        act_done_d     = 1'b0;
        cnt_d          = cnt_q;
        last_d         = last_q;

        // A request restarts from the slot base in any state and beats a same-cycle tick.
        if (act_req) begin
            rom_addr_d = {act_id, {SLOT_W{1'b0}}};
            state_d    = S_WAIT;
            act_busy_d = 1'b1;
            cnt_d      = '0;
        end else begin
            case (state_q)
                S_WAIT: state_d = S_LOAD;
                S_LOAD: begin
                    state_d        = S_HOLD;
                    sprite_id_d    = desc_sprite;
                    sprite_valid_d = 1'b1;
                    cnt_d          = (desc_dur == '0) ? DUR_W'(1) : desc_dur;
                    last_d         = desc_last;
                end
                S_HOLD: begin
                    if (frame_tick) begin
                        if (cnt_q > DUR_W'(1)) begin
                            cnt_d = cnt_q - DUR_W'(1);
                        end else if (last_q) begin
                            state_d    = S_IDLE;
                            act_busy_d = 1'b0;
                            act_done_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_W'(1);
                            state_d    = S_WAIT;
                            cnt_d      = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rom_addr_q     <= '0;
            sprite_id_q    <= '0;
            sprite_valid_q <= 1'b0;
            act_busy_q     <= 1'b0;
            act_done_q     <= 1'b0;
            cnt_q          <= '0;
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rom_addr_q     <= rom_addr_d;
            sprite_id_q    <= sprite_id_d;
            sprite_valid_q <= sprite_valid_d;
            act_busy_q     <= act_busy_d;
            act_done_q     <= act_done_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sprite_id    = sprite_id_q;
    assign sprite_valid = sprite_valid_q;
    assign act_busy     = act_busy_q;
    assign act_done     = act_done_q;
endmodule

// File: tb/tb_action_sequencer.sv
// tb/tb_action_sequencer.sv - randomized and directed checks of action_sequencer
// against a frame-timeline model driven by a synchronous ROM model.
module tb_action_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        act_req;
    logic [2:0]  act_id;
    logic        frame_tick;
    logic [7:0]  rom_addr;
    logic [12:0] rom_data;
    logic [7:0]  sprite_id;
    logic        sprite_valid;
    logic        act_busy;
    logic        act_done;

    logic [12:0] rom_mem [256];

    int checks = 0;
    int errors = 0;

    // Model: where the action is in its frame list, not how the FSM encodes it.
    logic [7:0] m_addr;
    logic [7:0] m_sprite;
    logic       m_valid;
    logic       m_busy;
    logic       m_done;
    int         m_gap;
    int         m_ticks;
    logic       m_last;

    action_sequencer dut (
        .clk(clk), .rst_n(rst_n), .act_req(act_req), .act_id(act_id),
        .frame_tick(frame_tick), .rom_addr(rom_addr), .rom_data(rom_data),
        .sprite_id(sprite_id), .sprite_valid(sprite_valid),
        .act_busy(act_busy), .act_done(act_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 8'h00; m_sprite = 8'h00; m_valid = 1'b0; m_busy = 1'b0;
        m_done = 1'b0; m_gap = 0; m_ticks = 0; m_last = 1'b0;
    endtask

    task automatic model_edge(input logic req, input logic [2:0] id, input logic tick);
        m_done = 1'b0;
        if (req) begin
            m_addr = {id, 5'b0};
            m_busy = 1'b1;
            m_gap  = 2;
        end else if (m_busy) begin
            if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) begin
                    m_sprite = rom_mem[m_addr][7:0];
                    m_valid  = 1'b1;
                    m_ticks  = (rom_mem[m_addr][11:8] == 4'd0) ? 1 : int'(rom_mem[m_addr][11:8]);
                    m_last   = rom_mem[m_addr][12];
                end
            end else if (tick) begin
                m_ticks--;
                if (m_ticks == 0) begin
                    if (m_last) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_addr = m_addr + 8'd1;
                        m_gap  = 2;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic req, input logic [2:0] id, input logic tick);
        @(negedge clk);
        act_req = req; act_id = id; frame_tick = tick;
        @(posedge clk);
        model_edge(req, id, tick);
        #1;
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        check("sprite_id", 32'(sprite_id), 32'(m_sprite));
        check("sprite_valid", 32'(sprite_valid), 32'(m_valid));
        check("act_busy", 32'(act_busy), 32'(m_busy));
        check("act_done", 32'(act_done), 32'(m_done));
    endtask

    initial begin
        rst_n = 1'b0; act_req = 1'b0; act_id = 3'd0; frame_tick = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = {($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)), 8'($urandom)};
        end
        rom_mem[8'h40] = {1'b0, 4'd2, 8'h11};
        rom_mem[8'h41] = {1'b1, 4'd1, 8'h12};
        rom_mem[8'h00] = {1'b1, 4'd0, 8'h05};
        rom_mem[8'hE0] = {1'b1, 4'd1, 8'h77};
        rom_mem[8'h60] = {1'b1, 4'd1, 8'h33};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(act_busy), 32'd0);
        check("reset_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single action 2: two-tick frame then a one-tick final frame.
        step(1'b1, 3'd2, 1'b0);
        check("single_base", 32'(rom_addr), 32'h40);
        check("single_busy", 32'(act_busy), 32'd1);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("single_spr0", 32'(sprite_id), 32'h11);
        step(1'b0, 3'd0, 1'b1);
        check("single_hold", 32'(rom_addr), 32'h40);
        step(1'b0, 3'd0, 1'b1);
        check("single_adv", 32'(rom_addr), 32'h41);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("single_spr1", 32'(sprite_id), 32'h12);
        step(1'b0, 3'd0, 1'b1);
        check("single_done", 32'(act_done), 32'd1);
        check("single_idle", 32'(act_busy), 32'd0);
        step(1'b0, 3'd0, 1'b0);
        check("single_pulse", 32'(act_done), 32'd0);
        check("single_keep", 32'(sprite_id), 32'h12);

        // Zero duration behaves as one tick.
        step(1'b1, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("zero_spr", 32'(sprite_id), 32'h05);
        step(1'b0, 3'd0, 1'b1);
        check("zero_done", 32'(act_done), 32'd1);

        // Tick during WAIT is ignored; HOLD still needs both ticks.
        step(1'b1, 3'd2, 1'b0);
        step(1'b0, 3'd0, 1'b1);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b1);
        check("wait_tick_ign", 32'(rom_addr), 32'h40);
        step(1'b0, 3'd0, 1'b1);
        check("wait_tick_adv", 32'(rom_addr), 32'h41);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);

        // Preempt during HOLD with action 7.
        step(1'b1, 3'd7, 1'b0);
        check("pre_addr", 32'(rom_addr), 32'hE0);
        check("pre_nodone", 32'(act_done), 32'd0);
        check("pre_keep", 32'(sprite_id), 32'h12);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("pre_spr", 32'(sprite_id), 32'h77);

        // Request together with the final tick wins.
        step(1'b1, 3'd3, 1'b1);
        check("same_nodone", 32'(act_done), 32'd0);
        check("same_addr", 32'(rom_addr), 32'h60);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        check("same_spr", 32'(sprite_id), 32'h33);

        // Asynchronous reset mid-HOLD.
        #2 rst_n = 1'b0;
        #1;
        check("async_spr", 32'(sprite_id), 32'd0);
        check("async_valid", 32'(sprite_valid), 32'd0);
        check("async_busy", 32'(act_busy), 32'd0);
        check("async_addr", 32'(rom_addr), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 3'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 39) == 0), 3'($urandom), ($urandom_range(0, 2) == 0));
        end
        step(1'b0, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
